// File: rtl/sample_capture_ctrl.sv
// Sample buffer sequencer: decimated capture of sample_in into a single-port sync RAM,
// then slow-rate playback of the buffer to the display register.
module sample_capture_ctrl #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 50000,
   parameter int ADDR_W    = 16,
   parameter int DECIM     = 96,
   parameter int PLAY_DIV  = 1000000,
   parameter int AUTO_TRIG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] sample_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] sample_count,
   output logic [1:0]        state_dbg
);

   localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int PCNT_W = (PLAY_DIV > 1) ? $clog2(PLAY_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CAPTURE  = 2'd1,
      S_PLAYBACK = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [DCNT_W-1:0]   dcnt;
   logic [PCNT_W-1:0]   pcnt;
   logic [ADDR_W-1:0]   wptr;
   logic [ADDR_W-1:0]   rptr;
   logic                rd_pend;
   logic [DATA_W-1:0]   disp_q;
   logic                disp_valid_q;
   logic                trig;
   logic                wr_slot;
   logic                rd_slot;

   always_comb begin
      trig    = start || ((AUTO_TRIG != 0) && (sample_in != '0));
      wr_slot = (state == S_CAPTURE) && (dcnt == DCNT_W'(DECIM - 1));
      rd_slot = (state == S_PLAYBACK) && (pcnt == PCNT_W'(PLAY_DIV - 1));

      state_next = state;
      case (state)
         S_IDLE:     if (trig) state_next = S_CAPTURE;
         S_CAPTURE:  if (wr_slot && (wptr == ADDR_W'(DEPTH - 1))) state_next = S_PLAYBACK;
         S_PLAYBACK: if (rd_pend && (rptr == ADDR_W'(DEPTH - 1))) state_next = S_DONE;
         S_DONE:     if (start) state_next = S_CAPTURE;
         default:    state_next = S_IDLE;
      endcase
      if (abort) state_next = S_IDLE;

      // Write strobe is suppressed the same cycle by abort/rst so no partial write lands.
      mem_we    = wr_slot && !abort && !rst;
      mem_wdata = mem_we ? sample_in : '0;
      mem_addr  = '0;
      if (state == S_CAPTURE)  mem_addr = wptr;
      if (state == S_PLAYBACK) mem_addr = rptr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         dcnt         <= '0;
         pcnt         <= '0;
         wptr         <= '0;
         rptr         <= '0;
         rd_pend      <= 1'b0;
         disp_q       <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         state        <= state_next;
         rd_pend      <= 1'b0;
         disp_valid_q <= 1'b0;
         if (abort) begin
            dcnt <= '0;
            pcnt <= '0;
            wptr <= '0;
            rptr <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  dcnt <= '0;
                  wptr <= '0;
               end
               S_CAPTURE: begin
                  dcnt <= wr_slot ? '0 : dcnt + DCNT_W'(1);
                  if (wr_slot) wptr <= wptr + ADDR_W'(1);
                  if (state_next == S_PLAYBACK) begin
                     pcnt <= '0;
                     rptr <= '0;
                  end
               end
               S_PLAYBACK: begin
                  pcnt    <= rd_slot ? '0 : pcnt + PCNT_W'(1);
                  rd_pend <= rd_slot;
                  // RAM data arrives the cycle after the address was presented.
                  if (rd_pend) begin
                     disp_q       <= mem_rdata;
                     disp_valid_q <= 1'b1;
                     if (rptr != ADDR_W'(DEPTH - 1)) rptr <= rptr + ADDR_W'(1);
                  end
               end
               S_DONE: begin
                  if (start) begin
                     dcnt <= '0;
                     wptr <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign disp_data    = disp_q;
   assign disp_valid   = disp_valid_q && !abort;
   assign busy         = (state == S_CAPTURE) || (state == S_PLAYBACK);
   assign done         = (state == S_DONE);
   assign sample_count = wptr;
   assign state_dbg    = state;

endmodule

// File: doc/sample_capture_ctrl.md
Name: sample_capture_ctrl

Overview:
Sequencer for the on-chip sample buffer: arms on a trigger, writes decimated 8-bit samples into a single-port synchronous RAM, then reads the buffer back at a slow display rate to the LED driver. Owns the only address/write-enable path to the buffer RAM, so capture and playback never collide. Sits between the sample source (currentNum bus) and the LED/display register.

Parameters:
DATA_W, 8, sample width
DEPTH, 50000, number of buffer entries captured and played back
ADDR_W, 16, buffer address width; must satisfy 2^ADDR_W >= DEPTH
DECIM, 96, clock cycles per captured sample
PLAY_DIV, 1000000, clock cycles per displayed sample
AUTO_TRIG, 1, 1 = nonzero sample_in also triggers capture from IDLE

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins capture from IDLE or DONE
abort  in  1  one-cycle pulse; returns to IDLE from any state
sample_in  in  DATA_W  live sample bus
mem_addr  out  ADDR_W  buffer RAM address
mem_we  out  1  buffer RAM write strobe, one cycle per sample
mem_wdata  out  DATA_W  buffer RAM write data
mem_rdata  in  DATA_W  buffer RAM read data, valid 1 cycle after mem_addr (sync read)
disp_data  out  DATA_W  sample presented to LEDs, held between updates
disp_valid  out  1  one-cycle pulse when disp_data updates
busy  out  1  high in CAPTURE or PLAYBACK
done  out  1  high in DONE
sample_count  out  ADDR_W  entries written in current capture

Behaviour:
- Reset: state IDLE; mem_addr, mem_wdata, disp_data, sample_count = 0; mem_we, disp_valid, busy, done = 0; all internal counters 0.
- States: IDLE, CAPTURE, PLAYBACK, DONE. busy/done decoded from registered state.
- IDLE -> CAPTURE when start=1, or AUTO_TRIG=1 and sample_in != 0. Write pointer and decimation counter cleared on entry.
- CAPTURE: decimation counter dcnt runs 0..DECIM-1, wraps. Cycle with dcnt == DECIM-1 asserts mem_we=1, mem_addr=wptr, mem_wdata=sample_in (value present that cycle); wptr and sample_count increment next cycle. First write DECIM cycles after the trigger edge. start ignored in CAPTURE.
- After write to address DEPTH-1: -> PLAYBACK next cycle; sample_count = DEPTH; mem_we never asserted outside CAPTURE.
- PLAYBACK: play counter pcnt runs 0..PLAY_DIV-1. On pcnt == PLAY_DIV-1, mem_addr=rptr; one cycle later disp_data <= mem_rdata and disp_valid=1 for exactly one cycle; rptr increments. First read issued PLAY_DIV cycles after PLAYBACK entry.
- After disp_valid for address DEPTH-1: -> DONE. disp_data retains last value.
- DONE: done=1 held; start -> CAPTURE (buffer overwritten from address 0, sample_count cleared). AUTO_TRIG does not retrigger from DONE.
- abort in any state: IDLE next cycle; mem_we and disp_valid forced 0 that same cycle; disp_data keeps its value; counters cleared. abort and start in the same cycle: abort wins.
- rst mid-capture or mid-playback: full reset values next edge, no partial write.
- Counters sized to hold DECIM-1, PLAY_DIV-1, DEPTH without overflow; no wrap past DEPTH-1 in either pointer.

Test Plan:
- Params DECIM=4, DEPTH=8, PLAY_DIV=3; rst then start pulse, sample_in ramps 1,2,3... each cycle -> mem_we pulses every 4 cycles at addr 0..7, first 4 cycles after start; sample_count reaches 8; state enters PLAYBACK.
- Continue from above with behavioural RAM -> 8 disp_valid pulses spaced 3 cycles, disp_data equals written values in address order; done=1 after the 8th; mem_we stays 0.
- AUTO_TRIG=1, start=0, sample_in 0 for 10 cycles then 8'h05 -> capture begins on the 8'h05 cycle; no writes before it.
- abort pulse asserted on the cycle mem_we would be high (addr 3) -> no write at addr 3, IDLE next cycle, busy=0, sample_count=0.
- In DONE, start pulse -> CAPTURE, new writes from addr 0, done drops next cycle; start pulse during CAPTURE -> no effect on wptr.
- rst asserted mid-PLAYBACK -> all outputs at reset values next edge; disp_data=0.
